// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable seconds countdown with a three-digit seven-segment display
//   (minutes, tens of seconds, ones of seconds). A prescaler divides clk
//   down to a one-second tick. When the count ticks from 1 to 0, the timer
//   raises expired and blinks "000" at 1 Hz until it is reloaded or reset.
//
// Parameters
//   CLK_HZ   clk cycles per one-second tick
//   MAX_SEC  largest loadable count; larger loads are clamped to this value
//
// Ports
//   clk      sole clock, rising edge
//   reset    synchronous, active-high reset
//   sec      [15:0] seconds value captured on set
//   set      single-cycle load strobe
//   run      count enable; 0 freezes the prescaler and the count
//   secLeft  [15:0] remaining seconds (the count register itself)
//   expired  high once the count has reached 0 by ticking
//   sevseg1  [6:0] minutes digit, active-low, gfedcba
//   sevseg2  [6:0] tens-of-seconds digit, active-low, gfedcba
//   sevseg3  [6:0] ones-of-seconds digit, active-low, gfedcba
module countdown_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int MAX_SEC = 599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sec,
  input  logic        set,
  input  logic        run,
  output logic [15:0] secLeft,
  output logic        expired,
  output logic [6:0]  sevseg1,
  output logic [6:0]  sevseg2,
  output logic [6:0]  sevseg3
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [15:0]   MAX_COUNT  = 16'(MAX_SEC);
  // Number of whole minutes the largest count can hold; bounds the
  // subtract-60 chain below.
  localparam int MIN_STEPS = MAX_SEC / 60;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PW-1:0] prescReg;
  logic [PW-1:0] prescNext;
  logic [15:0]   countReg;
  logic [15:0]   countNext;
  logic          expiredReg;
  logic          expiredNext;
  logic          tick;

  // The prescaler also keeps running while expired so that the blink
  // continues even if run is dropped after the timer has finished.
  assign tick = (run || expiredReg) && (prescReg == PRESC_LAST);

  always_comb begin
    prescNext   = prescReg;
    countNext   = countReg;
    expiredNext = expiredReg;
    if (set) begin
      // A load wins over a coincident tick; that tick is simply lost.
      countNext   = (sec > MAX_COUNT) ? MAX_COUNT : sec;
      prescNext   = '0;
      expiredNext = 1'b0;
    end else begin
      if (run || expiredReg) begin
        prescNext = tick ? '0 : prescReg + 1'b1;
      end
      // Ticks at count 0 do nothing: no wrap, and a timer loaded with 0
      // stays idle rather than expiring.
      if (tick && run && (countReg != 16'd0)) begin
        countNext = countReg - 16'd1;
        if (countReg == 16'd1) begin
          expiredNext = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescReg   <= '0;
      countReg   <= '0;
      expiredReg <= 1'b0;
    end else begin
      prescReg   <= prescNext;
      countReg   <= countNext;
      expiredReg <= expiredNext;
    end
  end

  assign secLeft = countReg;
  assign expired = expiredReg;

  // Binary to minutes / tens / ones by repeated conditional subtraction.
  // Fully combinational, so the digits settle within the same cycle for
  // every count up to MAX_SEC.
  logic [15:0] bcdRem;
  logic [3:0]  digit [3];

  always_comb begin
    bcdRem   = countReg;
    digit[0] = 4'd0;
    digit[1] = 4'd0;
    digit[2] = 4'd0;
    for (int i = 0; i < MIN_STEPS; i++) begin
      if (bcdRem >= 16'd60) begin
        bcdRem   = bcdRem - 16'd60;
        digit[0] = digit[0] + 4'd1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (bcdRem >= 16'd10) begin
        bcdRem   = bcdRem - 16'd10;
        digit[1] = digit[1] + 4'd1;
      end
    end
    digit[2] = bcdRem[3:0];
  end

  function automatic logic [6:0] segEncode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Second half of each prescaler period blanks the display while expired.
  logic blinkOff;
  assign blinkOff = prescReg >= PRESC_HALF;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gDigit
      logic [6:0] segReg;
      always_ff @(posedge clk) begin
        if (reset) begin
          segReg <= SEG_ZERO;
        end else if (expiredReg) begin
          segReg <= blinkOff ? SEG_BLANK : SEG_ZERO;
        end else begin
          segReg <= segEncode(digit[gi]);
        end
      end
    end
  endgenerate

  assign sevseg1 = gDigit[0].segReg;
  assign sevseg2 = gDigit[1].segReg;
  assign sevseg3 = gDigit[2].segReg;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int HZ   = 10;
  localparam int MAXS = 599;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sec;
  logic        set;
  logic        run;
  logic [15:0] secLeft;
  logic        expired;
  logic [6:0]  sevseg1;
  logic [6:0]  sevseg2;
  logic [6:0]  sevseg3;

  int nCompared = 0;
  int nMismatch = 0;

  countdown_timer #(.CLK_HZ(HZ), .MAX_SEC(MAXS)) dut (
    .clk     (clk),
    .reset   (reset),
    .sec     (sec),
    .set     (set),
    .run     (run),
    .secLeft (secLeft),
    .expired (expired),
    .sevseg1 (sevseg1),
    .sevseg2 (sevseg2),
    .sevseg3 (sevseg3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Seconds remaining, position within the current second, and expiry,
  // tracked as plain integers; the display is the digit image of the
  // previous cycle's state.
  int         mCount = 0;
  int         mPhase = 0;
  bit         mExp   = 1'b0;
  bit         modelValid = 1'b0;
  logic [6:0] mSeg [3];

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(posedge clk) begin
    bit secondEnds;
    if (reset) begin
      mCount = 0;
      mPhase = 0;
      mExp   = 1'b0;
      for (int k = 0; k < 3; k++) mSeg[k] = S0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (mExp) begin
        for (int k = 0; k < 3; k++) mSeg[k] = (mPhase < HZ / 2) ? S0 : SB;
      end else begin
        mSeg[0] = glyph(mCount / 60);
        mSeg[1] = glyph((mCount % 60) / 10);
        mSeg[2] = glyph(mCount % 10);
      end
      secondEnds = (run || mExp) && (mPhase == HZ - 1);
      if (set) begin
        mCount = (int'(sec) > MAXS) ? MAXS : int'(sec);
        mPhase = 0;
        mExp   = 1'b0;
      end else begin
        if (run || mExp) mPhase = (mPhase + 1) % HZ;
        if (secondEnds && run && mCount > 0) begin
          mCount = mCount - 1;
          if (mCount == 0) mExp = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      check("secLeft", 32'(secLeft), 32'(mCount));
      check("expired", 32'(expired), 32'(mExp));
      check("sevseg1", 32'(sevseg1), 32'(mSeg[0]));
      check("sevseg2", 32'(sevseg2), 32'(mSeg[1]));
      check("sevseg3", 32'(sevseg3), 32'(mSeg[2]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load(input int value, input logic runVal);
    set = 1'b1;
    sec = 16'(value);
    run = runVal;
    @(negedge clk);
    set = 1'b0;
    $display("[%0t] load sec=%0d run=%0b -> secLeft=%0d", $time, value, runVal, secLeft);
  endtask

  task automatic checkSegs(input string name, input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c);
    check(name, 32'({sevseg1, sevseg2, sevseg3}), 32'({a, b, c}));
  endtask

  initial begin
    reset = 1'b1;
    set   = 1'b0;
    run   = 1'b0;
    sec   = 16'd0;
    repeat (2) @(negedge clk);
    $display("[%0t] reset state", $time);
    check("rst_secLeft", 32'(secLeft), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    checkSegs("rst_segs", S0, S0, S0);
    reset = 1'b0;
    @(negedge clk);

    // 125 s: 2:05, first decrement after one full prescaler period.
    load(125, 1'b1);
    check("l125_secLeft", 32'(secLeft), 32'd125);
    @(negedge clk);
    checkSegs("l125_segs", S2, S0, S5);
    repeat (8) @(negedge clk);
    check("l125_before_tick", 32'(secLeft), 32'd125);
    @(negedge clk);
    check("l125_tick", 32'(secLeft), 32'd124);
    @(negedge clk);
    checkSegs("l124_segs", S2, S0, S4);
    $display("[%0t] countdown 125 -> 124 done", $time);

    // Over-range load clamps to 9:59.
    load(700, 1'b0);
    check("clamp_secLeft", 32'(secLeft), 32'd599);
    @(negedge clk);
    checkSegs("clamp_segs", S9, S5, S9);

    // 2 s to expiry, then the 1 Hz blink.
    load(2, 1'b1);
    repeat (19) @(negedge clk);
    check("exp_pre_secLeft", 32'(secLeft), 32'd1);
    check("exp_pre_expired", 32'(expired), 32'd0);
    @(negedge clk);
    check("exp_secLeft", 32'(secLeft), 32'd0);
    check("exp_expired", 32'(expired), 32'd1);
    checkSegs("exp_segs_lag", S0, S0, S1);
    @(negedge clk);
    checkSegs("blink_on", S0, S0, S0);
    repeat (5) @(negedge clk);
    checkSegs("blink_off", SB, SB, SB);
    repeat (5) @(negedge clk);
    checkSegs("blink_on2", S0, S0, S0);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check("exp_hold_norun", 32'(expired), 32'd1);
    $display("[%0t] expiry and blink done", $time);

    // run=0 freezes; set on a due tick loads without decrementing.
    load(3, 1'b0);
    check("freeze_clear_exp", 32'(expired), 32'd0);
    repeat (49) @(negedge clk);
    check("freeze_secLeft", 32'(secLeft), 32'd3);
    run = 1'b1;
    repeat (9) @(negedge clk);
    check("due_pre_secLeft", 32'(secLeft), 32'd3);
    load(7, 1'b1);
    check("set_vs_tick", 32'(secLeft), 32'd7);
    repeat (10) @(negedge clk);
    check("after_set_tick", 32'(secLeft), 32'd6);

    // Reset mid-count abandons the count.
    load(60, 1'b1);
    repeat (14) @(negedge clk);
    check("mid_secLeft", 32'(secLeft), 32'd59);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("[%0t] reset mid-count", $time);
    check("midrst_secLeft", 32'(secLeft), 32'd0);
    check("midrst_expired", 32'(expired), 32'd0);
    checkSegs("midrst_segs", S0, S0, S0);
    repeat (30) @(negedge clk);
    check("midrst_no_exp", 32'(expired), 32'd0);

    // Reset beats a simultaneous set.
    reset = 1'b1;
    set   = 1'b1;
    sec   = 16'd42;
    @(negedge clk);
    reset = 1'b0;
    set   = 1'b0;
    $display("[%0t] reset with set", $time);
    check("rst_over_set", 32'(secLeft), 32'd0);

    // Loading 0 is idle: no wrap, no expiry.
    load(0, 1'b1);
    repeat (30) @(negedge clk);
    check("zero_secLeft", 32'(secLeft), 32'd0);
    check("zero_expired", 32'(expired), 32'd0);
    run = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
